// File: rtl/lv_scan_reg_bist_rsp.sv
// Responder for the LV scan-register BIST handshake: saves, pattern-tests and
// restores one register per request, returning one ack with a pass/fail flag.
module lv_scan_reg_bist_rsp #(
  parameter int unsigned       LV_SCAN_REG_NUM = 8,
  parameter int unsigned       REG_DW          = 8,
  parameter logic [REG_DW-1:0] BIST_PAT0       = 8'h55,
  parameter logic [REG_DW-1:0] BIST_PAT1       = 8'hAA,
  parameter logic [REG_DW-1:0] BIST_BIT_MASK   = 8'hFF,
  parameter int unsigned       ADDR_W          = (LV_SCAN_REG_NUM > 1) ? $clog2(LV_SCAN_REG_NUM) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bist_en,
  input  logic              i_bist_scan_reg_req,
  output logic              o_scan_reg_bist_ack,
  output logic              o_scan_reg_bist_err,
  output logic [ADDR_W-1:0] o_bist_reg_addr,
  output logic              o_bist_reg_rd,
  output logic              o_bist_reg_wr,
  output logic [REG_DW-1:0] o_bist_reg_wdata,
  input  logic [REG_DW-1:0] i_bist_reg_rdata,
  output logic              o_bist_busy,
  output logic [ADDR_W:0]   o_bist_err_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_ORIG, S_CAP_ORIG, S_WR_P0, S_RD_P0, S_CMP_P0,
    S_WR_P1, S_RD_P1, S_CMP_P1, S_RESTORE, S_ACK
  } state_e;

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(LV_SCAN_REG_NUM - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [REG_DW-1:0] orig_q, orig_d;
  logic              flag_q, flag_d;
  logic              abort_q, abort_d;
  logic              guard_q;
  logic [REG_DW-1:0] wdata_d;

  logic              rd_q, wr_q, ack_q, err_q, busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [REG_DW-1:0] wdata_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    orig_d  = orig_q;
    flag_d  = flag_q;
    abort_d = abort_q;
    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (!i_bist_en) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (i_bist_scan_reg_req && !guard_q) begin
          state_d = S_RD_ORIG;
        end
      end
      S_RD_ORIG: begin
        flag_d  = 1'b0;
        state_d = i_bist_en ? S_CAP_ORIG : S_IDLE;
      end
      S_CAP_ORIG: begin
        orig_d  = i_bist_reg_rdata;
        state_d = i_bist_en ? S_WR_P0 : S_IDLE;
      end
      S_WR_P0, S_RD_P0, S_CMP_P0, S_WR_P1, S_RD_P1, S_CMP_P1: begin
        if (state_q == S_CMP_P0 && |((i_bist_reg_rdata ^ BIST_PAT0) & BIST_BIT_MASK))
          flag_d = 1'b1;
        if (state_q == S_CMP_P1 && |((i_bist_reg_rdata ^ BIST_PAT1) & BIST_BIT_MASK))
          flag_d = 1'b1;
        // Once the original is saved, losing enable still writes it back
        if (!i_bist_en) begin
          state_d = S_RESTORE;
          abort_d = 1'b1;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
      S_RESTORE: state_d = (i_bist_en && !abort_q) ? S_ACK : S_IDLE;
      S_ACK: begin
        if (flag_q && cnt_q != '1) cnt_d = cnt_q + (ADDR_W+1)'(1);
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + ADDR_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wdata_d = '0;
    case (state_d)
      S_WR_P0:   wdata_d = BIST_PAT0;
      S_WR_P1:   wdata_d = BIST_PAT1;
      S_RESTORE: wdata_d = orig_d;
      default:   wdata_d = '0;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      orig_q  <= '0;
      flag_q  <= 1'b0;
      abort_q <= 1'b0;
      guard_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      orig_q  <= orig_d;
      flag_q  <= flag_d;
      abort_q <= abort_d;
      guard_q <= (state_q == S_ACK);
      rd_q    <= (state_d == S_RD_ORIG) || (state_d == S_RD_P0) || (state_d == S_RD_P1);
      wr_q    <= (state_d == S_WR_P0) || (state_d == S_WR_P1) || (state_d == S_RESTORE);
      ack_q   <= (state_d == S_ACK);
      err_q   <= (state_d == S_ACK) && flag_d;
      busy_q  <= (state_d != S_IDLE);
      addr_q  <= (state_d == S_IDLE) ? '0 : idx_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_scan_reg_bist_ack = ack_q;
  assign o_scan_reg_bist_err = err_q;
  assign o_bist_reg_addr     = addr_q;
  assign o_bist_reg_rd       = rd_q;
  assign o_bist_reg_wr       = wr_q;
  assign o_bist_reg_wdata    = wdata_q;
  assign o_bist_busy         = busy_q;
  assign o_bist_err_cnt      = cnt_q;

endmodule

// File: tb/tb_lv_scan_reg_bist_rsp.sv
// Scoreboard bench: a full-mask and a 0xF0-mask responder share one bank model.
module tb_lv_scan_reg_bist_rsp;

  typedef struct {
    int addr;
    bit err;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, req;
  logic [7:0] rdata;

  logic       a_ack, a_err, a_rd, a_wr, a_busy;
  logic [2:0] a_addr;
  logic [7:0] a_wdata;
  logic [3:0] a_cnt;
  logic       b_ack, b_err, b_rd, b_wr, b_busy;
  logic [2:0] b_addr;
  logic [7:0] b_wdata;
  logic [3:0] b_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  exp_t qa[$];
  exp_t qb[$];

  localparam logic [7:0] ORIG [8] = '{8'h12, 8'hC3, 8'h0F, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hA5};
  logic [7:0] mem [8] = '{8'h12, 8'hC3, 8'h0F, 8'h3C, 8'hFF, 8'h00, 8'h5A, 8'hA5};
  logic [7:0] stuck [8];

  lv_scan_reg_bist_rsp dut_a (
    .i_clk(clk), .i_rst(rst), .i_bist_en(en), .i_bist_scan_reg_req(req),
    .o_scan_reg_bist_ack(a_ack), .o_scan_reg_bist_err(a_err),
    .o_bist_reg_addr(a_addr), .o_bist_reg_rd(a_rd), .o_bist_reg_wr(a_wr),
    .o_bist_reg_wdata(a_wdata), .i_bist_reg_rdata(rdata),
    .o_bist_busy(a_busy), .o_bist_err_cnt(a_cnt)
  );

  lv_scan_reg_bist_rsp #(.BIST_BIT_MASK(8'hF0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_bist_en(en), .i_bist_scan_reg_req(req),
    .o_scan_reg_bist_ack(b_ack), .o_scan_reg_bist_err(b_err),
    .o_bist_reg_addr(b_addr), .o_bist_reg_rd(b_rd), .o_bist_reg_wr(b_wr),
    .o_bist_reg_wdata(b_wdata), .i_bist_reg_rdata(rdata),
    .o_bist_busy(b_busy), .o_bist_err_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank: read data one cycle after rd; stuck-at-1 bits applied on read
  always @(posedge clk) begin
    if (a_rd) begin
      rdata  <= mem[a_addr] | stuck[a_addr];
      rd_cnt <= rd_cnt + 1;
    end
    if (a_wr) begin
      mem[a_addr] <= a_wdata;
      wr_cnt      <= wr_cnt + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int req_v);
    total++;
    if (act != req_v) begin
      bad++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t", nm, act, act, req_v, req_v, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_ack) begin
      if (qa.size() == 0) begin
        chk("unexpected_ack_a", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("ack_a_addr", int'(a_addr), e.addr);
        chk("ack_a_err", int'(a_err), int'(e.err));
        chk("ack_a_cycle", cyc, e.cyc);
      end
    end
    if (a_rd || a_wr) chk("rd_wr_exclusive", int'(a_rd & a_wr), 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_ack) begin
      if (qb.size() == 0) begin
        chk("unexpected_ack_b", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("ack_b_addr", int'(b_addr), e.addr);
        chk("ack_b_err", int'(b_err), int'(e.err));
        chk("ack_b_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one request at a negedge; ack is expected 10 intervals later.
  task automatic do_req(input int addr, input bit ea, input bit eb, input bit slow);
    exp_t e;
    int   rd0, wr0;
    bit   seen;
    rd0    = rd_cnt;
    wr0    = wr_cnt;
    e.addr = addr;
    e.err  = ea;
    e.cyc  = cyc + 10;
    qa.push_back(e);
    e.err  = eb;
    qb.push_back(e);
    req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (a_ack) seen = 1'b1;
    end
    chk("ack_seen", int'(seen), 1);
    chk("rd_count", rd_cnt - rd0, 3);
    chk("wr_count", wr_cnt - wr0, 3);
    if (slow) begin
      repeat (2) @(negedge clk);
      req = 1'b0;
      chk("guard_no_reentry", int'(a_busy), 0);
      @(negedge clk);
    end else begin
      req = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    for (int i = 0; i < 8; i++) stuck[i] = 8'h00;
    rst = 1'b1;
    en  = 1'b0;
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(a_ack), 0);
    chk("rst_err", int'(a_err), 0);
    chk("rst_rd", int'(a_rd), 0);
    chk("rst_wr", int'(a_wr), 0);
    chk("rst_addr", int'(a_addr), 0);
    chk("rst_wdata", int'(a_wdata), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_cnt", int'(a_cnt), 0);
    rst = 1'b0;
    en  = 1'b1;

    for (int i = 0; i < 8; i++) do_req(i, 1'b0, 1'b0, 1'b0);
    do_req(0, 1'b0, 1'b0, 1'b0);
    chk("good_cnt_a", int'(a_cnt), 0);
    chk("good_cnt_b", int'(b_cnt), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("restored_%0d", i), int'(mem[i]), int'(ORIG[i]));

    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    stuck[3] = 8'h04;
    for (int i = 0; i < 8; i++) do_req(i, (i == 3), 1'b0, (i == 7));
    chk("fault_cnt_a", int'(a_cnt), 1);
    chk("fault_cnt_b", int'(b_cnt), 0);
    stuck[3] = 8'h00;

    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    stuck[0] = 8'h04;
    do_req(0, 1'b1, 1'b0, 1'b0);
    stuck[0] = 8'h00;
    req = 1'b1;
    repeat (6) @(negedge clk);
    chk("wrp1_wr", int'(a_wr), 1);
    chk("wrp1_wdata", int'(a_wdata), 8'hAA);
    en  = 1'b0;
    req = 1'b0;
    @(negedge clk);
    chk("abort_restore_wr", int'(a_wr), 1);
    chk("abort_restore_wdata", int'(a_wdata), 8'hC3);
    chk("abort_restore_addr", int'(a_addr), 1);
    chk("abort_cnt_before", int'(a_cnt), 1);
    @(negedge clk);
    chk("abort_idle_busy", int'(a_busy), 0);
    @(negedge clk);
    chk("abort_cnt_cleared", int'(a_cnt), 0);
    en = 1'b1;
    do_req(0, 1'b0, 1'b0, 1'b0);

    req = 1'b1;
    repeat (4) @(negedge clk);
    chk("rdp0_rd", int'(a_rd), 1);
    chk("rdp0_addr", int'(a_addr), 1);
    wc  = wr_cnt;
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(a_busy), 0);
    chk("arst_rd", int'(a_rd), 0);
    chk("arst_wr", int'(a_wr), 0);
    chk("arst_addr", int'(a_addr), 0);
    chk("arst_ack", int'(a_ack), 0);
    chk("arst_busy_b", int'(b_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_restore_write", wr_cnt, wc);
    chk("arst_idle_busy", int'(a_busy), 0);

    repeat (3) @(negedge clk);
    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
